// File: rtl/ram_test_top.sv
// ram_test_top: self-running exerciser for two external asynchronous SRAMs.
//
// After reset it writes a known pattern into a Ram1 window and copies the
// window into Ram2. When RAM2_VERIFY_EN is defined, it then re-reads Ram2,
// counts the mismatching words and writes the count to Ram2 at STATUS_ADDR.
// Finally it parks in DONE with both SRAMs deselected.
//
// Pattern for window index i: P(i) = i[15:0] ^ 16'hA5A5, at BASE_ADDR + i.
//
// Build option:
//   RAM2_VERIFY_EN  compiles in the VERIFY/STATUS states and the mismatch counter.
//
// Ports:
//   Clk, Rst                 clock and synchronous active-high reset
//   RamN_EN/OE/WE            active-low chip enable / output enable / write enable
//   RamN_address [17:0]      SRAM address
//   RamN_data    [15:0]      SRAM data; driven only during that SRAM's write accesses
//
// Access shapes, one phase per cycle:
//   write: SETUP (EN=0, data driven), STROBE (WE=0), HOLD (WE=1, data still driven)
//   read : ADDR (EN=0, OE=0), SAMPLE (data captured at the edge ending SAMPLE)
//
// Every pin, including the data-bus output enables, comes straight from a register.
// At each edge the next state is computed, and then the pin registers are
// loaded from a decode of that next state.
module ram_test_top #(
  parameter int unsigned WORDS       = 16,
  parameter logic [17:0] BASE_ADDR   = 18'h00000,
  parameter logic [17:0] STATUS_ADDR = 18'h3FFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        Ram1_EN,
  output logic        Ram1_OE,
  output logic        Ram1_WE,
  output logic [17:0] Ram1_address,
  inout  wire  [15:0] Ram1_data,
  output logic        Ram2_EN,
  output logic        Ram2_OE,
  output logic        Ram2_WE,
  output logic [17:0] Ram2_address,
  inout  wire  [15:0] Ram2_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_COPY   = 3'd2;
`ifdef RAM2_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_STATUS = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [15:0] LAST_IDX    = 16'(WORDS - 1);
  localparam logic [15:0] PATTERN_KEY = 16'hA5A5;

  // state_q: current FSM state.
  // phase_q: cycle within the current access. Within COPY, phases 0-1 are the
  //          Ram1 read and phases 2-4 are the Ram2 write.
  // idx_q:   current window index.
  logic [2:0]  state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [15:0] idx_q, idx_d;
  logic        last_word;
  logic [17:0] win_addr;

  logic        en1_q, en1_d, oe1_q, oe1_d, we1_q, we1_d, drv1_q, drv1_d;
  logic [17:0] addr1_q, addr1_d;
  logic [15:0] dout1_q, dout1_d;
  logic        en2_q, en2_d, oe2_q, oe2_d, we2_q, we2_d, drv2_q, drv2_d;
  logic [17:0] addr2_q, addr2_d;
  logic [15:0] dout2_q, dout2_d;

`ifdef RAM2_VERIFY_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  // Next-state logic: sequence the phases within an access, then step the window index.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    last_word = (idx_q == LAST_IDX);
`ifdef RAM2_VERIFY_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_FILL;
        phase_d = 3'd0;
        idx_d   = 16'd0;
      end
      S_FILL: begin
        if (phase_q == 3'd2) begin
          phase_d = 3'd0;
          if (last_word) begin
            state_d = S_COPY;
            idx_d   = 16'd0;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      S_COPY: begin
        if (phase_q == 3'd4) begin
          phase_d = 3'd0;
          if (last_word) begin
`ifdef RAM2_VERIFY_EN
            state_d = S_VERIFY;
`else
            state_d = S_DONE;
`endif
            idx_d = 16'd0;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
`ifdef RAM2_VERIFY_EN
      S_VERIFY: begin
        if (phase_q == 3'd1) begin
          // This edge ends SAMPLE, so the Ram2 bus holds the word being read back.
          if ((Ram2_data != (idx_q ^ PATTERN_KEY)) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
          end
          phase_d = 3'd0;
          if (last_word) begin
            state_d = S_STATUS;
            idx_d   = 16'd0;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      S_STATUS: begin
        if (phase_q == 3'd2) begin
          state_d = S_DONE;
          phase_d = 3'd0;
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
`endif
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin decode from the next state. Pins default to idle, and the addresses and
  // output data hold their previous values.
  always_comb begin
    en1_d   = 1'b1;
    oe1_d   = 1'b1;
    we1_d   = 1'b1;
    drv1_d  = 1'b0;
    addr1_d = addr1_q;
    dout1_d = dout1_q;
    en2_d   = 1'b1;
    oe2_d   = 1'b1;
    we2_d   = 1'b1;
    drv2_d  = 1'b0;
    addr2_d = addr2_q;
    dout2_d = dout2_q;
    win_addr = BASE_ADDR + {2'b00, idx_d};
    case (state_d)
      S_FILL: begin
        en1_d   = 1'b0;
        we1_d   = (phase_d != 3'd1);
        drv1_d  = 1'b1;
        addr1_d = win_addr;
        dout1_d = idx_d ^ PATTERN_KEY;
      end
      S_COPY: begin
        if (phase_d < 3'd2) begin
          en1_d   = 1'b0;
          oe1_d   = 1'b0;
          addr1_d = win_addr;
        end else begin
          en2_d   = 1'b0;
          we2_d   = (phase_d != 3'd3);
          drv2_d  = 1'b1;
          addr2_d = win_addr;
          // Entering phase 2 is the edge that ends the Ram1 SAMPLE cycle, so the
          // word read from Ram1 is captured straight into the Ram2 write register.
          if (phase_d == 3'd2) begin
            dout2_d = Ram1_data;
          end
        end
      end
`ifdef RAM2_VERIFY_EN
      S_VERIFY: begin
        en2_d   = 1'b0;
        oe2_d   = 1'b0;
        addr2_d = win_addr;
      end
      S_STATUS: begin
        en2_d   = 1'b0;
        we2_d   = (phase_d != 3'd1);
        drv2_d  = 1'b1;
        addr2_d = STATUS_ADDR;
        dout2_d = cnt_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      phase_q <= 3'd0;
      idx_q   <= 16'd0;
      en1_q   <= 1'b1;
      oe1_q   <= 1'b1;
      we1_q   <= 1'b1;
      drv1_q  <= 1'b0;
      addr1_q <= 18'd0;
      dout1_q <= 16'd0;
      en2_q   <= 1'b1;
      oe2_q   <= 1'b1;
      we2_q   <= 1'b1;
      drv2_q  <= 1'b0;
      addr2_q <= 18'd0;
      dout2_q <= 16'd0;
`ifdef RAM2_VERIFY_EN
      cnt_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      en1_q   <= en1_d;
      oe1_q   <= oe1_d;
      we1_q   <= we1_d;
      drv1_q  <= drv1_d;
      addr1_q <= addr1_d;
      dout1_q <= dout1_d;
      en2_q   <= en2_d;
      oe2_q   <= oe2_d;
      we2_q   <= we2_d;
      drv2_q  <= drv2_d;
      addr2_q <= addr2_d;
      dout2_q <= dout2_d;
`ifdef RAM2_VERIFY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign Ram1_EN      = en1_q;
  assign Ram1_OE      = oe1_q;
  assign Ram1_WE      = we1_q;
  assign Ram1_address = addr1_q;
  assign Ram1_data    = drv1_q ? dout1_q : 16'hzzzz;
  assign Ram2_EN      = en2_q;
  assign Ram2_OE      = oe2_q;
  assign Ram2_WE      = we2_q;
  assign Ram2_address = addr2_q;
  assign Ram2_data    = drv2_q ? dout2_q : 16'hzzzz;

endmodule

// File: tb/tb_ram_test_top.sv
// Bench for ram_test_top. It holds behavioural models of both SRAMs, with an
// optional read corruption on Ram2. Each cycle it checks the pin protocol.
// After each run it checks both memory images against the pattern rule.
// Undriven data buses are pulled up, so a released bus reads as 16'hFFFF.
module tb_ram_test_top;

  localparam int          WORDS  = 16;
  localparam logic [17:0] BASE   = 18'h00000;
  localparam logic [17:0] STATUS = 18'h3FFFF;
`ifdef RAM2_VERIFY_EN
  localparam int EXP_DONE    = 1 + 10 * WORDS + 3;
  localparam int EXP_STROBE2 = WORDS + 1;
`else
  localparam int EXP_DONE    = 1 + 8 * WORDS;
  localparam int EXP_STROBE2 = WORDS;
`endif

  logic        Clk, Rst;
  logic        Ram1_EN, Ram1_OE, Ram1_WE, Ram2_EN, Ram2_OE, Ram2_WE;
  logic [17:0] Ram1_address, Ram2_address;
  wire  [15:0] Ram1_data, Ram2_data;

  ram_test_top #(.WORDS(WORDS), .BASE_ADDR(BASE), .STATUS_ADDR(STATUS)) dut (
    .Clk(Clk), .Rst(Rst),
    .Ram1_EN(Ram1_EN), .Ram1_OE(Ram1_OE), .Ram1_WE(Ram1_WE),
    .Ram1_address(Ram1_address), .Ram1_data(Ram1_data),
    .Ram2_EN(Ram2_EN), .Ram2_OE(Ram2_OE), .Ram2_WE(Ram2_WE),
    .Ram2_address(Ram2_address), .Ram2_data(Ram2_data)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- SRAM models ----------------
  logic [15:0] mem1 [0:262143];
  logic [15:0] mem2 [0:262143];
  logic [15:0] fault_mask [0:WORDS-1];
  logic [15:0] rd1_val, rd2_val;
  logic [17:0] off2;

  for (genvar b = 0; b < 16; b++) begin : g_pull
    pullup (Ram1_data[b]);
    pullup (Ram2_data[b]);
  end

  always_comb rd1_val = mem1[Ram1_address];
  always_comb begin
    rd2_val = mem2[Ram2_address];
    off2    = Ram2_address - BASE;
    if (off2 < 18'(WORDS)) rd2_val = rd2_val ^ fault_mask[int'(off2)];
  end
  assign Ram1_data = (!Ram1_EN && !Ram1_OE) ? rd1_val : 16'hzzzz;
  assign Ram2_data = (!Ram2_EN && !Ram2_OE) ? rd2_val : 16'hzzzz;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int first_active, last_active;
  int strobes [2];
  logic        prev_en [2];
  logic        prev_we [2];
  logic [17:0] prev_addr [2];
  logic [15:0] prev_data [2];

  typedef struct {
    logic        sel;    // 0 = Ram1, 1 = Ram2
    logic [17:0] addr;
    logic [15:0] exp;
  } mem_vec_t;
  mem_vec_t vecs [8];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload();
    for (int i = 0; i < WORDS; i++) begin
      mem1[18'(BASE + 18'(i))] = 16'($urandom);
      mem2[18'(BASE + 18'(i))] = 16'($urandom);
    end
    mem2[STATUS] = 16'hDEAD;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < WORDS; i++) fault_mask[i] = 16'h0000;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_ctl"}, {Ram1_EN, Ram1_OE, Ram1_WE, Ram2_EN, Ram2_OE, Ram2_WE}, 6'b111111);
    chk({tag, "_addr1"}, Ram1_address, 18'h0);
    chk({tag, "_addr2"}, Ram2_address, 18'h0);
    chk({tag, "_bus1_z"}, Ram1_data, 16'hFFFF);
    chk({tag, "_bus2_z"}, Ram2_data, 16'hFFFF);
  endtask

  task automatic do_reset(input int n);
    Rst = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      check_reset_pins("reset");
    end
    for (int p = 0; p < 2; p++) begin
      prev_en[p] = 1'b1;
      prev_we[p] = 1'b1;
      prev_addr[p] = 18'h0;
      prev_data[p] = 16'h0;
    end
    Rst = 1'b0;
  endtask

  // Per-cycle protocol check for one SRAM port. A write strobe stores data in the model.
  task automatic port_check(input int p, input logic en, input logic oe, input logic we,
                            input logic [17:0] addr, input logic [15:0] data, input logic [15:0] rd);
    string pn;
    pn = (p == 0) ? "ram1" : "ram2";
    chk({pn, "_oe_we_both_low"}, {31'd0, !oe && !we}, 32'd0);
    if (en) begin
      chk({pn, "_idle_oe_we"}, {oe, we}, 2'b11);
      chk({pn, "_idle_bus_z"}, data, 16'hFFFF);
    end else if (!oe) begin
      chk({pn, "_read_bus_undriven"}, data, rd);
    end
    if (!en && !we) begin
      strobes[p]++;
      chk({pn, "_setup_before_strobe"}, {prev_en[p], prev_we[p]}, 2'b01);
      chk({pn, "_strobe_data_stable"}, data, prev_data[p]);
      chk({pn, "_strobe_addr_stable"}, addr, prev_addr[p]);
      if (p == 0) mem1[addr] = data;
      else        mem2[addr] = data;
    end
    if (!prev_we[p] && we) begin
      chk({pn, "_hold_en"}, {31'd0, en}, 32'd0);
      chk({pn, "_hold_data"}, data, prev_data[p]);
      chk({pn, "_hold_addr"}, addr, prev_addr[p]);
    end
    prev_en[p]   = en;
    prev_we[p]   = we;
    prev_addr[p] = addr;
    prev_data[p] = data;
  endtask

  task automatic monitor_cycle(input int k);
    if (!Ram1_EN || !Ram2_EN) begin
      if (first_active < 0) first_active = k;
      last_active = k;
    end
    if (k == 0) begin
      chk("first_access_ram1_write_setup", {Ram1_EN, Ram1_OE, Ram1_WE}, 3'b011);
      chk("first_access_addr", Ram1_address, BASE);
    end
    chk("one_sram_at_a_time", {31'd0, !Ram1_EN && !Ram2_EN}, 32'd0);
    port_check(0, Ram1_EN, Ram1_OE, Ram1_WE, Ram1_address, Ram1_data, rd1_val);
    port_check(1, Ram2_EN, Ram2_OE, Ram2_WE, Ram2_address, Ram2_data, rd2_val);
`ifndef RAM2_VERIFY_EN
    chk("ram2_oe_never_low", {31'd0, Ram2_OE}, 32'd1);
    chk("status_addr_untouched", {31'd0, !Ram2_EN && (Ram2_address == STATUS)}, 32'd0);
`endif
    if (k >= EXP_DONE - 1) begin
      chk("done_deselected", {Ram1_EN, Ram2_EN}, 2'b11);
      chk("done_addr1_hold", Ram1_address, 18'(BASE + 18'(WORDS - 1)));
`ifdef RAM2_VERIFY_EN
      chk("done_addr2_hold", Ram2_address, STATUS);
`else
      chk("done_addr2_hold", Ram2_address, 18'(BASE + 18'(WORDS - 1)));
`endif
    end
  endtask

  // One run from reset release. Cycle k is the k-th rising edge with Rst low,
  // and is observed at the falling edge after it. abort_word >= 0 asserts Rst
  // during the STROBE of that COPY word.
  task automatic run_sequence(input int abort_word);
    logic aborted;
    aborted = 1'b0;
    first_active = -1;
    last_active  = -1;
    strobes[0] = 0;
    strobes[1] = 0;
    for (int k = 0; k < EXP_DONE + 8; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      monitor_cycle(k);
      if (abort_word >= 0 && !Ram2_EN && !Ram2_WE && Ram2_address == 18'(BASE + 18'(abort_word))) begin
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check_reset_pins("abort");
        aborted = 1'b1;
        break;
      end
    end
    if (abort_word >= 0) begin
      chk("abort_point_reached", {31'd0, aborted}, 32'd1);
    end else begin
      chk("first_active_cycle", first_active, 0);
      chk("cycles_to_done", last_active + 2, EXP_DONE);
      chk("ram1_strobe_count", strobes[0], WORDS);
      chk("ram2_strobe_count", strobes[1], EXP_STROBE2);
    end
  endtask

  // Memory-image check: table vectors first, then the whole window from the pattern rule.
  task automatic check_mem();
    int nbad;
    nbad = 0;
    for (int i = 0; i < WORDS; i++) if (fault_mask[i] != 16'h0) nbad++;
`ifdef RAM2_VERIFY_EN
    vecs[7].exp = 16'(nbad);
`else
    vecs[7].exp = 16'hDEAD;
`endif
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("mem_vec%0d", i),
          vecs[i].sel ? mem2[vecs[i].addr] : mem1[vecs[i].addr], vecs[i].exp);
    end
    for (int i = 0; i < WORDS; i++) begin
      chk($sformatf("ram1_word%0d", i), mem1[18'(BASE + 18'(i))], 16'(i) ^ 16'hA5A5);
      chk($sformatf("ram2_word%0d", i), mem2[18'(BASE + 18'(i))], 16'(i) ^ 16'hA5A5);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nf, aw;
    Rst = 1'b1;
    vecs[0] = '{1'b0, 18'd0,  16'hA5A5};
    vecs[1] = '{1'b0, 18'd1,  16'hA5A4};
    vecs[2] = '{1'b0, 18'd15, 16'hA5AA};
    vecs[3] = '{1'b1, 18'd0,  16'hA5A5};
    vecs[4] = '{1'b1, 18'd1,  16'hA5A4};
    vecs[5] = '{1'b1, 18'd3,  16'hA5A6};
    vecs[6] = '{1'b1, 18'd15, 16'hA5AA};
    vecs[7] = '{1'b1, STATUS, 16'h0000};

    // Plain run after a 5-cycle reset.
    clear_faults();
    preload();
    do_reset(5);
    run_sequence(-1);
    check_mem();

    // Ram2 read corruption at address 3.
    clear_faults();
    fault_mask[3] = 16'h0001;
    preload();
    do_reset(2);
    run_sequence(-1);
    check_mem();

    // Reset during the COPY strobe of word 7, then a full run.
    clear_faults();
    preload();
    do_reset(2);
    run_sequence(7);
    preload();
    do_reset(3);
    run_sequence(-1);
    check_mem();

    // Randomised faults, reset lengths and abort points.
    for (int r = 0; r < 4; r++) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int f = 0; f < nf; f++) fault_mask[$urandom_range(0, WORDS - 1)] = 16'($urandom_range(1, 16'hFFFF));
      preload();
      do_reset($urandom_range(1, 6));
      if ($urandom_range(0, 1) == 1) begin
        aw = $urandom_range(0, WORDS - 1);
        run_sequence(aw);
        preload();
        do_reset($urandom_range(1, 4));
      end
      run_sequence(-1);
      check_mem();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_test_top.md
# ram_test_top

Self-running dual-SRAM exerciser: the board-level top of the memory bring-up design. It drives two external asynchronous SRAMs (Ram1, Ram2) through their raw pins. After reset it fills a Ram1 window with a known pattern, copies that window into Ram2, optionally re-reads Ram2 to count mismatches, then parks with both SRAMs deselected. The module is named `ram_test_top`; it replaces the bare `top` wrapper.

## Interface
Parameters:
- WORDS, 16: number of words filled, copied and verified (1..65536).
- BASE_ADDR, 18'h00000: first address of the window in both SRAMs.
- STATUS_ADDR, 18'h3FFFF: Ram2 address that receives the mismatch count; must lie outside the window.

Ports:
- Clk  input  1: system clock; all logic on the rising edge.
- Rst  input  1: synchronous, active-high reset.
- Ram1_EN, Ram1_OE, Ram1_WE  output  1 each: Ram1 chip enable, output enable, write enable; all active-low.
- Ram1_address  output  18: Ram1 address.
- Ram1_data  inout  16: Ram1 data. Driven only during Ram1 write cycles; high-Z otherwise.
- Ram2_EN, Ram2_OE, Ram2_WE, Ram2_address, Ram2_data: same as the Ram1 ports, for Ram2.

## Operation
- Pattern for window index i (0..WORDS-1): P(i) = i[15:0] ^ 16'hA5A5, at address BASE_ADDR + i (18-bit add, wraps modulo 2^18).
- FSM states: IDLE → FILL → COPY → VERIFY → STATUS → DONE.
- IDLE: entered on reset. Leaves after one cycle with Rst low.
- FILL: writes P(i) to Ram1 for i = 0..WORDS-1, one write access per word.
- COPY: for each i, reads Ram1 at BASE_ADDR+i, then writes the captured word to Ram2 at the same address.
- VERIFY: reads Ram2 for each i and compares the word against P(i). Each mismatch increments a 16-bit counter that saturates at 16'hFFFF.
- STATUS: writes the counter value to Ram2 at STATUS_ADDR.
- DONE: terminal state. Both EN/OE/WE high, both data buses high-Z, addresses hold their last value. Only Rst leaves DONE.
- The SRAM not being accessed in a given cycle has EN=OE=WE=1 and its data bus at high-Z.
- Write access, 3 cycles:
  - SETUP: EN=0, OE=1, WE=1, address and data driven.
  - STROBE: WE=0.
  - HOLD: WE=1, address and data still driven.
- Read access, 2 cycles:
  - ADDR: EN=0, OE=0, WE=1, bus high-Z.
  - SAMPLE: same pin levels; data is captured at the rising edge that ends this cycle.
- OE and WE are never both low. The data bus is never driven while OE=0.

## Timing
- Reset values, registered outputs: all EN/OE/WE = 1, both addresses = 0, both data buses high-Z, mismatch counter = 0, state IDLE.
- Reset is sampled every cycle in every state. Asserting it mid-access aborts the access: on the next edge the outputs return to their reset values, and the full sequence restarts from IDLE after release.
- Cycle 0 is the first rising edge with Rst low. IDLE occupies cycle 0; the FILL SETUP of word 0 appears after that edge.
- Per-word cost: FILL 3 cycles; COPY 5 cycles (2 read + 3 write, back-to-back); VERIFY 2 cycles; STATUS 3 cycles total.
- DONE is reached after 1 + 10·WORDS + 3 cycles with verify built in, or 1 + 8·WORDS without it. For WORDS=16 that is 164 and 129 cycles respectively.
- All pin outputs, including data output enables, come straight from registers, so outputs are glitch-free.

## Configuration
- `RAM2_VERIFY_EN` defined: the VERIFY and STATUS states and the mismatch counter are compiled in.
- `RAM2_VERIFY_EN` not defined: COPY goes directly to DONE, the counter logic is absent, and Ram2 never sees a read access.

## Test plan
- Reset check: hold Rst high for 5 cycles → every cycle shows EN/OE/WE=1, addresses=0 and both data buses Z; release → Ram1_EN falls exactly one cycle later.
- Fill (WORDS=16, BASE_ADDR=0, behavioural SRAM models) → Ram1[0]=16'hA5A5, Ram1[1]=16'hA5A4, Ram1[15]=16'hA5AA. WE is low exactly one cycle per word, with data stable on both edges around the strobe.
- Copy with verify on → after 164 cycles Ram2[0..15] equals Ram1[0..15] and Ram2[18'h3FFFF]=16'h0000; all pins are idle thereafter.
- Fault injection: the Ram2 model corrupts address 3 on read → Ram2[18'h3FFFF]=16'h0001.
- Mid-operation reset: assert Rst during the STROBE of COPY word 7 → WE=1 and the bus is Z on the next edge; after release the sequence restarts with a Ram1 write at address 0 and completes normally.
- Macro off: build without `RAM2_VERIFY_EN` → DONE at cycle 129, Ram2_OE stays 1 for the whole run, and STATUS_ADDR is never written.
